alu_wb_buffer: RTL and testbench
================================

# alu_wb_buffer

Writeback-side stage directly downstream of the 64-bit execute ALU (ADD/SUB/AND/XOR plus overflow flag). It captures each ALU result with its destination tag and overflow flag into a small in-order buffer, and presents entries to the register-file write port with a valid/ready handshake. It suppresses writes for overflowing operations and for register 0. It also maintains a sticky overflow flag and a saturating overflow event counter for the control/status logic.

## Interface
- DATA_W, 64, ALU result width
- TAG_W, 5, destination register index width
- DEPTH, 2, buffer entries; power of two, >= 2
- CNT_W, 16, overflow event counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  buffer can accept an entry
- in_result  in  DATA_W  ALU selected_result (signed)
- in_overflow  in  1  ALU Overflow
- in_op  in  2  ALU select code of the op that produced in_result
- in_dest  in  TAG_W  destination register index
- out_valid  out  1  head entry valid
- out_ready  in  1  register file consumes head entry
- out_result  out  DATA_W  head entry result
- out_dest  out  TAG_W  head entry destination
- out_op  out  2  head entry op code
- out_we  out  1  head entry write enable; 0 = discard, no write
- ovf_sticky  out  1  set by any accepted overflowing entry
- ovf_count  out  CNT_W  number of accepted overflowing entries, saturating
- ovf_clear  in  1  clears ovf_sticky and ovf_count

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready; strict FIFO order.
- in_ready = !full && !rst; no pop-through when full.
- Push and pop in the same cycle are both legal when neither full nor empty. Occupancy is unchanged.
- out_we = out_valid && !entry.ovf && (entry.dest != 0).
- Entries with out_we = 0 still require an out_ready handshake to pop.
- Overflow entries are checked only at push. The stored ovf bit equals in_overflow at push, forced to 0 when in_op is AND (2'b10) or XOR (2'b11).
- On a push with stored ovf = 1: ovf_sticky <= 1; ovf_count <= ovf_count + 1, saturating at all-ones.
- ovf_clear: ovf_sticky <= 0 and ovf_count <= 0. If an overflow push happens in the same cycle, the push wins: sticky = 1, count = 1.
- Pointers are log2(DEPTH) bits wide plus one wrap bit. full/empty are derived from pointer equality plus the wrap bit.
- out_result, out_dest, and out_op are don't-care while out_valid = 0. They are driven from head storage and must not be X after the first push.

## Timing
- Reset values: out_valid 0, out_we 0, in_ready 0 while rst is high, then 1 in the first cycle after deassert; ovf_sticky 0, ovf_count 0, pointers 0.
- Reset asserted mid-operation discards all entries immediately, and out_valid drops asynchronously.
- Latency: a push at edge N gives out_valid = 1 in cycle N+1 (registered path).
- in_ready depends only on occupancy. There is no combinational path from out_ready to in_ready.
- ovf_sticky and ovf_count update at the same edge as the push.

## Configuration
- ALU_WB_BYPASS_EN defined: when the buffer is empty, in_valid = 1, and out_ready = 1, the entry goes straight to the outputs in the same cycle with 0 latency and is not stored.
  - out_valid, out_result, out_dest, out_op, and out_we then become combinational from the in_* ports.
  - Overflow counting still applies to the bypassed entry.
- ALU_WB_BYPASS_EN undefined: fully registered, 1-cycle minimum latency as above.

## Structure
- Shared package alu_pkg holds:
  - DATA_W and TAG_W defaults
  - ALU op codes: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11
  - packed entry struct {result, dest, op, ovf}
- Sub-module sync_fifo: parameterised storage, pointers, full/empty for one entry struct.
- alu_wb_buffer wraps sync_fifo and adds the write-enable, overflow masking, counter, and bypass logic.

## Test plan
- Push result 0x10, dest 3, op ADD, ovf 0, with out_ready = 1 -> next cycle out_valid = 1, out_result = 0x10, out_dest = 3, out_we = 1; pops; buffer empty.
- out_ready = 0 with pushes of 0xA, then 0xB, then 0xC -> in_ready = 0 after the second push and 0xC is not accepted. Raising out_ready then yields 0xA, then 0xB, in order.
- Push result 0x8000_0000_0000_0000, op ADD, ovf 1, dest 7 -> out_we = 0, ovf_sticky = 1, ovf_count = 1. Same data with op XOR and ovf 1 -> ovf_count stays 1.
- Push dest 0, ovf 0 -> out_valid = 1, out_we = 0; the entry pops on out_ready.
- ovf_clear in the same cycle as an overflowing push -> ovf_sticky = 1, ovf_count = 1. ovf_clear alone next cycle -> both 0.
- Two entries buffered, rst pulsed mid-cycle -> out_valid = 0 immediately, ovf_count = 0. After release, in_ready = 1 and the first new push appears unaffected by stale data.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/writeback definitions: default widths, op codes, buffer entry layout
// and the overflow-masking helper used when an ALU result is captured.
package alu_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_TAG_W  = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_TAG_W-1:0]  dest;
        logic [1:0]            op;
        logic                  ovf;
    } wb_entry_t;

    // Logic ops cannot overflow, so any flag the ALU raises for them is ignored.
    function automatic logic ovf_effective(input logic [1:0] op, input logic ovf);
        logic eff;
        case (op)
            OP_AND:  eff = 1'b0;
            OP_XOR:  eff = 1'b0;
            OP_ADD:  eff = ovf;
            OP_SUB:  eff = ovf;
            default: eff = ovf;
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order storage for writeback entries; pointers carry one extra wrap bit so
// full and empty are distinguished by pointer comparison alone.
module sync_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t wr_data,
    input  logic      pop,
    output wb_entry_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    wb_entry_t   mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Storage is cleared on reset so the head never presents unknown data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_wb_buffer.sv
// Writeback buffer behind the execute ALU: queues results, gates register-file writes,
// tracks overflow events. Define ALU_WB_BYPASS_EN for a zero-latency path when empty.
module alu_wb_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_overflow,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_dest,
    output logic [1:0]        out_op,
    output logic              out_we,
    output logic              ovf_sticky,
    output logic [CNT_W-1:0]  ovf_count,
    input  logic              ovf_clear
);

    wb_entry_t        in_entry_s;
    wb_entry_t        head_s;
    wb_entry_t        sel_s;
    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             bypass_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_event_s;
    logic             ovf_sticky_r;
    logic [CNT_W-1:0] ovf_count_r;

    // Only occupancy (and reset) gates acceptance; out_ready never reaches in_ready.
    assign in_ready = !full_s && !rst;
    assign accept_s = in_valid && in_ready;

`ifdef ALU_WB_BYPASS_EN
    assign bypass_s = accept_s && empty_s && out_ready;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s      = accept_s && !bypass_s;
    assign pop_s       = !empty_s && out_ready;
    assign ovf_event_s = accept_s && in_entry_s.ovf;

    // Capture the incoming ALU result with its effective overflow flag.
    always_comb begin
        in_entry_s        = '0;
        in_entry_s.result = in_result;
        in_entry_s.dest   = in_dest;
        in_entry_s.op     = in_op;
        in_entry_s.ovf    = ovf_effective(in_op, in_overflow);
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (in_entry_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Select between the stored head and the bypassed input entry.
    always_comb begin
        sel_s     = head_s;
        out_valid = !empty_s;
        if (bypass_s) begin
            sel_s     = in_entry_s;
            out_valid = 1'b1;
        end else begin
            sel_s     = head_s;
            out_valid = !empty_s;
        end
    end

    assign out_result = sel_s.result;
    assign out_dest   = sel_s.dest;
    assign out_op     = sel_s.op;
    assign out_we     = out_valid && !sel_s.ovf && (sel_s.dest != '0);

    // Sticky flag and saturating counter; an overflow push outranks a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky_r <= 1'b0;
            ovf_count_r  <= '0;
        end else if (ovf_event_s) begin
            ovf_sticky_r <= 1'b1;
            if (ovf_clear) begin
                ovf_count_r <= CNT_W'(1);
            end else if (ovf_count_r == {CNT_W{1'b1}}) begin
                ovf_count_r <= ovf_count_r;
            end else begin
                ovf_count_r <= ovf_count_r + CNT_W'(1);
            end
        end else if (ovf_clear) begin
            ovf_sticky_r <= 1'b0;
            ovf_count_r  <= '0;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
            ovf_count_r  <= ovf_count_r;
        end
    end

    assign ovf_sticky = ovf_sticky_r;
    assign ovf_count  = ovf_count_r;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer (default build): directed vector table,
// reset corner sequence, and randomized traffic against a queue-based model.
module tb_alu_wb_buffer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_result = 64'd0;
    logic        in_overflow = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [4:0]  in_dest = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic [4:0]  out_dest;
    logic [1:0]  out_op;
    logic        out_we;
    logic        ovf_sticky;
    logic [15:0] ovf_count;
    logic        ovf_clear = 1'b0;

    int errors = 0;
    int checks = 0;

    alu_wb_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_op(in_op), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_op(out_op), .out_we(out_we),
        .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] res;
        logic        ovf;
        logic [1:0]  op;
        logic [4:0]  dest;
        logic        ordy;
        logic        clr;
        logic        e_valid;
        logic [63:0] e_res;
        logic [4:0]  e_dest;
        logic        e_we;
        logic        e_rdy;
        logic        e_st;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dest;
        logic [1:0]  op;
        logic        ovf;
    } ment_t;

    vec_t  tbl [18];
    ment_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic ovf, input logic [1:0] op,
                         input logic [4:0] dest, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid = v; in_result = res; in_overflow = ovf; in_op = op;
        in_dest = dest; out_ready = ordy; ovf_clear = clr;
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [63:0] res, input logic ovf, input logic [1:0] op,
                                input logic [4:0] dest, input logic ordy, input logic clr,
                                input logic ev, input logic [63:0] er, input logic [4:0] ed,
                                input logic ew, input logic erdy, input logic est, input logic [15:0] ec);
        vec_t r;
        r.v = v; r.res = res; r.ovf = ovf; r.op = op; r.dest = dest; r.ordy = ordy; r.clr = clr;
        r.e_valid = ev; r.e_res = er; r.e_dest = ed; r.e_we = ew; r.e_rdy = erdy; r.e_st = est; r.e_cnt = ec;
        return r;
    endfunction

    initial begin
        logic [63:0] big;
        big = 64'h8000_0000_0000_0000;
        //           v     res          ovf   op     dest   ordy  clr    ev    eres         edest  ewe   erdy  est   ecnt
        tbl[0]  = mk(1'b1, 64'h10,      1'b0, OP_ADD, 5'd3, 1'b1, 1'b0,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b0, 16'd0);
        tbl[1]  = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, 64'h10,      5'd3,  1'b1, 1'b1, 1'b0, 16'd0);
        tbl[2]  = mk(1'b1, 64'hA,       1'b0, OP_ADD, 5'd1, 1'b0, 1'b0,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b0, 16'd0);
        tbl[3]  = mk(1'b1, 64'hB,       1'b0, OP_SUB, 5'd2, 1'b0, 1'b0,  1'b1, 64'hA,       5'd1,  1'b1, 1'b1, 1'b0, 16'd0);
        tbl[4]  = mk(1'b1, 64'hC,       1'b0, OP_ADD, 5'd3, 1'b0, 1'b0,  1'b1, 64'hA,       5'd1,  1'b1, 1'b0, 1'b0, 16'd0);
        tbl[5]  = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, 64'hA,       5'd1,  1'b1, 1'b0, 1'b0, 16'd0);
        tbl[6]  = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, 64'hB,       5'd2,  1'b1, 1'b1, 1'b0, 16'd0);
        tbl[7]  = mk(1'b1, big,         1'b1, OP_ADD, 5'd7, 1'b0, 1'b0,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b0, 16'd0);
        tbl[8]  = mk(1'b1, big,         1'b1, OP_XOR, 5'd7, 1'b0, 1'b0,  1'b1, big,         5'd7,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[9]  = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, big,         5'd7,  1'b0, 1'b0, 1'b1, 16'd1);
        tbl[10] = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, big,         5'd7,  1'b1, 1'b1, 1'b1, 16'd1);
        tbl[11] = mk(1'b1, 64'h55,      1'b0, OP_ADD, 5'd0, 1'b0, 1'b0,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[12] = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b0, 1'b0,  1'b1, 64'h55,      5'd0,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[13] = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, 64'h55,      5'd0,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[14] = mk(1'b1, 64'h1,       1'b1, OP_SUB, 5'd4, 1'b0, 1'b1,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[15] = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b1, 1'b0,  1'b1, 64'h1,       5'd4,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[16] = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b0, 1'b1,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b1, 16'd1);
        tbl[17] = mk(1'b0, 64'h0,       1'b0, OP_ADD, 5'd0, 1'b0, 1'b0,  1'b0, 64'h0,       5'd0,  1'b0, 1'b1, 1'b0, 16'd0);

        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_we", {63'd0, out_we}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        chk("rst_count", {48'd0, ovf_count}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].res, tbl[i].ovf, tbl[i].op, tbl[i].dest, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].e_rdy});
            chk($sformatf("vec%0d_out_we", i), {63'd0, out_we}, {63'd0, tbl[i].e_we});
            chk($sformatf("vec%0d_sticky", i), {63'd0, ovf_sticky}, {63'd0, tbl[i].e_st});
            chk($sformatf("vec%0d_count", i), {48'd0, ovf_count}, {48'd0, tbl[i].e_cnt});
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_result", i), out_result, tbl[i].e_res);
                chk($sformatf("vec%0d_dest", i), {59'd0, out_dest}, {59'd0, tbl[i].e_dest});
            end
        end

        // Reset asserted with two entries buffered
        drive(1'b1, 64'h111, 1'b1, OP_ADD, 5'd5, 1'b0, 1'b0);
        drive(1'b1, 64'h222, 1'b0, OP_ADD, 5'd6, 1'b0, 1'b0);
        drive(1'b0, 64'h0, 1'b0, OP_ADD, 5'd0, 1'b0, 1'b0);
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        chk("pre_rst_count", {48'd0, ovf_count}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("async_rst_count", {48'd0, ovf_count}, 64'd0);
        chk("async_rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 64'h333, 1'b0, OP_SUB, 5'd9, 1'b0, 1'b0);
        drive(1'b0, 64'h0, 1'b0, OP_ADD, 5'd0, 1'b1, 1'b0);
        chk("fresh_valid", {63'd0, out_valid}, 64'd1);
        chk("fresh_result", out_result, 64'h333);
        chk("fresh_dest", {59'd0, out_dest}, 64'd9);
        chk("fresh_we", {63'd0, out_we}, 64'd1);
        chk("fresh_op", {62'd0, out_op}, {62'd0, OP_SUB});

        // Randomized traffic against a queue model
        drive(1'b0, 64'h0, 1'b0, OP_ADD, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        begin
            logic        m_st;
            int          m_cnt;
            logic        exp_rdy, exp_vld, acc, pp, eff;
            ment_t       e;
            m_st = 1'b0; m_cnt = 0;
            for (int c = 0; c < 400; c++) begin
                drive(1'b1 & ($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
                exp_rdy = (q.size() < 2);
                exp_vld = (q.size() > 0);
                chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
                chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
                chk("rnd_sticky", {63'd0, ovf_sticky}, {63'd0, m_st});
                chk("rnd_count", {48'd0, ovf_count}, 64'(m_cnt));
                if (exp_vld) begin
                    chk("rnd_result", out_result, q[0].res);
                    chk("rnd_dest", {59'd0, out_dest}, {59'd0, q[0].dest});
                    chk("rnd_op", {62'd0, out_op}, {62'd0, q[0].op});
                    chk("rnd_we", {63'd0, out_we}, {63'd0, (!q[0].ovf && q[0].dest != 5'd0)});
                end else begin
                    chk("rnd_we_idle", {63'd0, out_we}, 64'd0);
                end
                acc = in_valid && exp_rdy;
                pp  = exp_vld && out_ready;
                eff = in_overflow && (in_op == OP_ADD || in_op == OP_SUB);
                if (pp) void'(q.pop_front());
                if (acc) begin
                    e.res = in_result; e.dest = in_dest; e.op = in_op; e.ovf = eff;
                    q.push_back(e);
                end
                if (acc && eff) begin
                    m_st = 1'b1;
                    m_cnt = ovf_clear ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
                end else if (ovf_clear) begin
                    m_st = 1'b0;
                    m_cnt = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
